// File: rtl/led_scanner.sv
// Activity-pattern driver for an LED bank: a prescaler paces bounce, rotate,
// blink and off patterns, with debug position and step-strobe outputs.
module led_scanner #(
    parameter int N_LEDS     = 8,
    parameter int TICK_DIV   = 2097152,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int POS_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic [POS_W-1:0]  pos,
    output logic              step
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    mode_e              mode_s;
    logic               tick;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_up_q, dir_up_d;
    logic               phase_q, phase_d;
    logic [N_LEDS-1:0]  pattern_q, pattern_d;
    logic               step_q;

    logic               bounce_up;
    logic [POS_W-1:0]   bounce_pos;
    logic [POS_W-1:0]   rotate_pos;
    logic [POS_W-1:0]   scan_pos;
    logic [N_LEDS-1:0]  scan_onehot;

    assign mode_s = mode_e'(mode);
    assign tick   = en && (cnt_q == CNT_LAST);

    // Direction is corrected at the endpoints before stepping, so each
    // endpoint is shown for exactly one step per sweep.
    always_comb begin
        bounce_up = dir_up_q;
        if (pos_q == POS_LAST) begin
            bounce_up = 1'b0;
        end else if (pos_q == '0) begin
            bounce_up = 1'b1;
        end

        if (N_LEDS == 1) begin
            bounce_pos = '0;
        end else if (bounce_up) begin
            bounce_pos = pos_q + 1'b1;
        end else begin
            bounce_pos = pos_q - 1'b1;
        end

        rotate_pos = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        scan_pos   = (mode_s == MODE_ROTATE) ? rotate_pos : bounce_pos;
    end

    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_onehot
            assign scan_onehot[gi] = (scan_pos == POS_W'(gi));
        end
    endgenerate

    always_comb begin
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        phase_d   = phase_q;
        pattern_d = pattern_q;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        if (tick) begin
            case (mode_s)
                MODE_BOUNCE: begin
                    pos_d     = scan_pos;
                    dir_up_d  = (N_LEDS == 1) ? dir_up_q : bounce_up;
                    pattern_d = scan_onehot;
                end
                MODE_ROTATE: begin
                    pos_d     = scan_pos;
                    pattern_d = scan_onehot;
                end
                MODE_BLINK: begin
                    phase_d   = ~phase_q;
                    pattern_d = phase_q ? '0 : '1;
                end
                MODE_OFF: begin
                    pattern_d = '0;
                end
                default: begin
                    pattern_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pos_q     <= '0;
            dir_up_q  <= 1'b1;
            phase_q   <= 1'b0;
            pattern_q <= N_LEDS'(1);
            step_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            phase_q   <= phase_d;
            pattern_q <= pattern_d;
            step_q    <= tick;
        end
    end

    generate
        if (ACTIVE_LOW) begin : g_led_low
            assign led = ~pattern_q;
        end else begin : g_led_high
            assign led = pattern_q;
        end
    endgenerate

    assign pos  = pos_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner: a stimulus process pushes expected step
// results from a behavioural model; a negedge monitor pops and compares.
module tb_led_scanner;

    localparam int N  = 8;
    localparam int TD = 4;
    localparam int PW = 5;

    typedef struct {
        logic [N-1:0]  led;
        logic [PW-1:0] pos;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [N-1:0]  led;
    logic [PW-1:0] pos;
    logic          step;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_seen = 1'b0;
    bit   mon_on = 1'b0;

    exp_t          sb[$];
    logic [N-1:0]  obs_led[$];
    logic [PW-1:0] obs_pos[$];
    logic [N-1:0]  last_led;
    logic [PW-1:0] last_pos;

    // Reference model state
    int           m_cnt, m_pos, m_dir, m_phase;
    logic [N-1:0] m_pat;

    led_scanner #(
        .N_LEDS    (N),
        .TICK_DIV  (TD),
        .ACTIVE_LOW(1'b1),
        .POS_W     (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .mode (mode),
        .led  (led),
        .pos  (pos),
        .step (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: on every step pop the scoreboard; between steps outputs must hold.
    always @(negedge clk) begin
        if (rst_seen === 1'b1) begin
            mon_on = 1'b1;
            chk("rst_led", int'(led), int'(8'hFE));
            chk("rst_pos", int'(pos), 0);
            chk("rst_step", int'(step), 0);
            last_led = 8'hFE;
            last_pos = '0;
        end else if (mon_on) begin
            if (step === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("step_led", int'(led), int'(e.led));
                    chk("step_pos", int'(pos), int'(e.pos));
                    chk("step_cycle", cyc, e.cyc);
                    last_led = e.led;
                    last_pos = e.pos;
                    obs_led.push_back(led);
                    obs_pos.push_back(pos);
                end
            end else begin
                chk("hold_step", int'(step), 0);
                chk("hold_led", int'(led), int'(last_led));
                chk("hold_pos", int'(pos), int'(last_pos));
            end
        end
    end

    // One clock of stimulus; the model predicts what the coming edge produces.
    task automatic clk1(input logic r, input logic e, input logic [1:0] m, output bit ticked);
        reset  = r;
        en     = e;
        mode   = m;
        ticked = 1'b0;
        if (r) begin
            m_cnt = 0; m_pos = 0; m_dir = 1; m_phase = 0; m_pat = N'(1);
        end else if (e) begin
            if (m_cnt == TD - 1) begin
                m_cnt  = 0;
                ticked = 1'b1;
                case (m)
                    2'd0: begin
                        if (N > 1) begin
                            if (m_pos == N - 1) m_dir = -1;
                            else if (m_pos == 0) m_dir = 1;
                            m_pos = m_pos + m_dir;
                        end
                        m_pat = N'(1) << m_pos;
                    end
                    2'd1: begin
                        m_pos = (m_pos + 1) % N;
                        m_pat = N'(1) << m_pos;
                    end
                    2'd2: begin
                        m_phase = 1 - m_phase;
                        m_pat   = (m_phase != 0) ? '1 : '0;
                    end
                    default: m_pat = '0;
                endcase
                sb.push_back('{~m_pat, PW'(m_pos), cyc + 1});
            end else begin
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic e, input logic [1:0] m);
        bit t;
        for (int i = 0; i < n; i++) clk1(1'b0, e, m, t);
    endtask

    // Run until n model ticks have occurred, plus one settling clock.
    task automatic run_steps(input int n, input logic [1:0] m);
        bit t;
        int got = 0;
        while (got < n) begin
            clk1(1'b0, 1'b1, m, t);
            if (t) got++;
        end
        clk1(1'b0, 1'b1, m, t);
    endtask

    task automatic clear_obs();
        obs_led.delete();
        obs_pos.delete();
    endtask

    initial begin
        bit t;
        int bounce_tab[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        int blink_tab[3]   = '{8'h00, 8'hFF, 8'h00};
        int budget;

        @(negedge clk);
        for (int i = 0; i < 3; i++) clk1(1'b1, 1'b0, 2'd0, t);
        chk("reset_led_direct", int'(led), int'(8'hFE));

        // Bounce sweep
        clear_obs();
        run_steps(16, 2'd0);
        chk("bounce_count", obs_pos.size(), 16);
        for (int i = 0; i < 16 && i < obs_pos.size(); i++)
            chk($sformatf("bounce_pos%0d", i), int'(obs_pos[i]), bounce_tab[i]);
        if (obs_led.size() > 0) chk("first_led", int'(obs_led[0]), int'(8'hFD));

        // Blink then off then resume bounce
        clear_obs();
        run_steps(3, 2'd2);
        chk("blink_count", obs_led.size(), 3);
        for (int i = 0; i < 3 && i < obs_led.size(); i++)
            chk($sformatf("blink_led%0d", i), int'(obs_led[i]), blink_tab[i]);
        clear_obs();
        run_steps(1, 2'd3);
        if (obs_led.size() > 0) begin
            chk("off_led", int'(obs_led[0]), int'(8'hFF));
            chk("off_pos", int'(obs_pos[0]), 2);
        end else chk("off_count", 0, 1);
        clear_obs();
        run_steps(1, 2'd0);
        if (obs_pos.size() > 0) chk("resume_pos", int'(obs_pos[0]), 3);
        else chk("resume_count", 0, 1);

        // Freeze mid-period
        idle(1, 1'b1, 2'd0);
        idle(10, 1'b0, 2'd0);
        clear_obs();
        run_steps(2, 2'd0);
        chk("freeze_count", obs_pos.size(), 2);
        if (obs_pos.size() == 2) begin
            chk("freeze_pos0", int'(obs_pos[0]), 4);
            chk("freeze_pos1", int'(obs_pos[1]), 5);
        end

        // Reset while descending through pos 5
        budget = 0;
        while (!(m_pos == 5 && m_dir == -1) && budget < 300) begin
            clk1(1'b0, 1'b1, 2'd0, t);
            budget++;
        end
        chk("reach_pos5_down", budget < 300, 1);
        clk1(1'b1, 1'b1, 2'd0, t);
        clear_obs();
        run_steps(2, 2'd0);
        chk("post_reset_count", obs_pos.size(), 2);
        if (obs_pos.size() == 2) begin
            chk("post_reset_pos0", int'(obs_pos[0]), 1);
            chk("post_reset_pos1", int'(obs_pos[1]), 2);
        end

        // Mode switch at the endpoints
        budget = 0;
        while (m_pos != N - 1 && budget < 20) begin run_steps(1, 2'd1); budget++; end
        clear_obs();
        run_steps(1, 2'd0);
        if (obs_pos.size() > 0) chk("switch_top", int'(obs_pos[0]), N - 2);
        else chk("switch_top_count", 0, 1);
        budget = 0;
        while (m_pos != 0 && budget < 20) begin run_steps(1, 2'd1); budget++; end
        clear_obs();
        run_steps(1, 2'd0);
        if (obs_pos.size() > 0) chk("switch_bottom", int'(obs_pos[0]), 1);
        else chk("switch_bottom_count", 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       r, e;
            logic [1:0] m;
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 9) != 0);
            m = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mode;
            clk1(r, e, m, t);
        end

        idle(4, 1'b0, 2'd0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
